ysyx22041405_rr_arbiter_n_m: RTL and testbench

Registered N-way request arbiter with encoded and one-hot grant outputs. It is the sequential, parametrised successor to the combinational lowest-index priority encoder. The block supports two modes, fixed lowest-index priority and round-robin, and offers each grant to a consumer through a valid/ready handshake. It sits between N requesters, such as bus masters or write-back sources, and a shared resource that accepts one winner at a time.

---
 rtl/ysyx22041405_rr_arbiter_n_m.sv | 102 ++++++++++
 tb/tb_ysyx22041405_rr_arbiter_n_m.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx22041405_rr_arbiter_n_m.sv
// Registered N-way arbiter (fixed or round-robin) with encoded and one-hot grant; 1-cycle latency.
// Backpressure: a presented grant holds unchanged until gnt_valid && gnt_ready.
module ysyx22041405_rr_arbiter_n_m #(
  parameter int N = 8,
  parameter int M = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [M-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot
);

  generate
    if (N < 2 || M != $clog2(N)) begin : g_bad_param
      $error("rr_arbiter: need N >= 2 and M == clog2(N)");
    end
  endgenerate

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [M:0]   N_EXT  = (M+1)'(N);
  localparam logic [M-1:0] LAST   = M'(N - 1);
  localparam logic [N-1:0] ONE_N  = N'(1);

  state_t       state, state_nxt;
  logic [M-1:0] ptr, ptr_nxt;
  logic [M-1:0] idx_nxt;
  logic [N-1:0] onehot_nxt;

  logic         handshake;
  logic         arb_point;
  logic         any_req;
  logic [M-1:0] scan_base;
  logic [N-1:0] req_rot;
  logic [M-1:0] rot_off;
  logic [M:0]   rr_sum;
  logic [M-1:0] fix_idx;
  logic [M-1:0] rr_idx;
  logic [M-1:0] win_idx;

  function automatic logic [M-1:0] lowest_set(input logic [N-1:0] v);
    lowest_set = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = M'(i);
    end
  endfunction

  assign handshake = (state == GRANT) && gnt_ready;
  assign arb_point = (state == IDLE) || handshake;
  assign any_req   = |req;

  // Pointer advance; the scan uses the advanced pointer on a handshake so the
  // requester just accepted drops to lowest priority in the same edge.
  assign ptr_nxt   = handshake ? ((gnt_idx == LAST) ? '0 : gnt_idx + M'(1)) : ptr;
  assign scan_base = ptr_nxt;

  // Rotating a doubled vector gives bit k = req[(base + k) mod N], wrapping at N.
  assign req_rot = N'({req, req} >> scan_base);
  assign rot_off = lowest_set(req_rot);
  assign rr_sum  = {1'b0, scan_base} + {1'b0, rot_off};
  assign rr_idx  = (rr_sum >= N_EXT) ? M'(rr_sum - N_EXT) : M'(rr_sum);

  assign fix_idx = lowest_set(req);
  assign win_idx = mode ? rr_idx : fix_idx;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = gnt_idx;
    onehot_nxt = gnt_onehot;
    if (arb_point) begin
      if (any_req) begin
        state_nxt  = GRANT;
        idx_nxt    = win_idx;
        onehot_nxt = ONE_N << win_idx;
      end else begin
        state_nxt  = IDLE;
        onehot_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      ptr        <= '0;
    end else begin
      state      <= state_nxt;
      gnt_idx    <= idx_nxt;
      gnt_onehot <= onehot_nxt;
      ptr        <= ptr_nxt;
    end
  end

  assign gnt_valid = (state == GRANT);

endmodule

// File: tb/tb_ysyx22041405_rr_arbiter_n_m.sv
// Bench for the N-way arbiter: an 8-way and a 5-way instance checked against a scan-based model.
module tb_ysyx22041405_rr_arbiter_n_m;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       mode = 1'b0;
  logic       gnt_ready = 1'b0;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;

  logic [4:0] req5 = '0;
  logic       mode5 = 1'b0;
  logic       gnt_ready5 = 1'b0;
  logic       gnt_valid5;
  logic [2:0] gnt_idx5;
  logic [4:0] gnt_onehot5;

  int errors = 0;
  int checks = 0;

  bit m_v;  int m_idx;  int m_p;
  bit m5_v; int m5_idx; int m5_p;

  always #5 clk = ~clk;

  ysyx22041405_rr_arbiter_n_m #(.N(8), .M(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .gnt_ready(gnt_ready),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt_onehot(gnt_onehot)
  );

  ysyx22041405_rr_arbiter_n_m #(.N(5), .M(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .mode(mode5), .gnt_ready(gnt_ready5),
    .gnt_valid(gnt_valid5), .gnt_idx(gnt_idx5), .gnt_onehot(gnt_onehot5)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Requester to be served: first set bit in scan order, or -1 if none.
  function automatic int pick(input logic [7:0] r, input int n, input logic md, input int p);
    for (int k = 0; k < n; k++) begin
      int i;
      i = md ? (p + k) % n : k;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_next(input int n, input logic [7:0] r, input logic md, input logic rdy,
                            inout bit v, inout int idx, inout int p);
    int w;
    bit accepted;
    accepted = v && rdy;
    if (!v || accepted) begin
      if (accepted) p = (idx + 1) % n;
      w = pick(r, n, md, p);
      if (w >= 0) begin
        v = 1'b1;
        idx = w;
      end else begin
        v = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_v = 0;  m_idx = 0;  m_p = 0;
    m5_v = 0; m5_idx = 0; m5_p = 0;
  endtask

  task automatic check_all();
    chk("n8_valid", int'(gnt_valid), int'(m_v));
    chk("n8_idx", int'(gnt_idx), m_idx);
    chk("n8_onehot", int'(gnt_onehot), m_v ? (1 << m_idx) : 0);
    chk("n5_valid", int'(gnt_valid5), int'(m5_v));
    chk("n5_idx", int'(gnt_idx5), m5_idx);
    chk("n5_onehot", int'(gnt_onehot5), m5_v ? (1 << m5_idx) : 0);
  endtask

  task automatic step(input logic [7:0] r, input logic md, input logic rd,
                      input logic [4:0] r5, input logic md5, input logic rd5);
    req = r; mode = md; gnt_ready = rd;
    req5 = r5; mode5 = md5; gnt_ready5 = rd5;
    model_next(8, r, md, rd, m_v, m_idx, m_p);
    model_next(5, {3'b000, r5}, md5, rd5, m5_v, m5_idx, m5_p);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic step8(input logic [7:0] r, input logic md, input logic rd);
    step(r, md, rd, 5'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    req = 8'hFF; mode = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(gnt_valid), 0);
    chk("rst_idx", int'(gnt_idx), 0);
    chk("rst_onehot", int'(gnt_onehot), 0);

    @(negedge clk);
    rst_n = 1'b1;
    step8(8'hFF, 1'b1, 1'b0);
    chk("rel_idx", int'(gnt_idx), 0);
    chk("rel_onehot", int'(gnt_onehot), 8'h01);

    // Fixed priority: requester 2 keeps winning
    for (int c = 0; c < 5; c++) begin
      step8(8'b1010_0100, 1'b0, 1'b1);
      chk("fix_idx", int'(gnt_idx), 2);
    end

    // Round-robin fairness from a clean pointer
    reset_pulse();
    for (int c = 0; c < 10; c++) begin
      step8(8'hFF, 1'b1, 1'b1);
      chk("rr_seq", int'(gnt_idx), c % 8);
      chk("rr_valid", int'(gnt_valid), 1);
    end

    // Backpressure: grant 3 held while req drops
    reset_pulse();
    step8(8'h08, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step8(8'h00, c[0], 1'b0);
      chk("bp_idx", int'(gnt_idx), 3);
      chk("bp_onehot", int'(gnt_onehot), 8'h08);
      chk("bp_valid", int'(gnt_valid), 1);
    end
    step8(8'h00, 1'b0, 1'b1);
    chk("bp_release_valid", int'(gnt_valid), 0);

    // Non-power-of-two wrap on the 5-way instance
    reset_pulse();
    step(8'h00, 1'b0, 1'b0, 5'b10001, 1'b1, 1'b0);
    chk("n5_first", int'(gnt_idx5), 0);
    step(8'h00, 1'b0, 1'b0, 5'b10001, 1'b1, 1'b1);
    chk("n5_second", int'(gnt_idx5), 4);
    step(8'h00, 1'b0, 1'b0, 5'b10001, 1'b1, 1'b1);
    chk("n5_wrap", int'(gnt_idx5), 0);

    // Randomized traffic on both instances
    for (int c = 0; c < 400; c++) begin
      logic [7:0] r;
      logic [4:0] r5;
      r  = 8'($urandom);
      r5 = 5'($urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      if ($urandom_range(0, 7) == 0) r5 = '0;
      step(r, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           r5, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      chk("n5_range", int'(gnt_idx5 < 3'd5), 1);
    end

    // Asynchronous reset while granting index 6
    reset_pulse();
    step8(8'h40, 1'b0, 1'b0);
    chk("pre_rst_idx", int'(gnt_idx), 6);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step8(8'hFF, 1'b1, 1'b1);
    chk("post_rst_idx", int'(gnt_idx), 0);
    step8(8'hFF, 1'b1, 1'b1);
    chk("post_rst_next", int'(gnt_idx), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
